// File: rtl/prog_load_run_ctrl_if.sv
// prog_load_run_ctrl_if
//   Bundles the program-word stream and the core-facing instruction-memory /
//   execute-control signals that the load/run controller sits between.
//   Signals:
//     S_VALID, S_DATA, S_READY  - program word stream (valid/ready)
//     W_EN, ADDRESS, W_INSTRUCTION - instruction-memory write port of the core
//     R_EN                      - core execute enable
//     CORE_RST                  - active-low reset to the core
//   Modports:
//     slave  - controller view (consumes the stream, drives the core port)
//     master - environment view (sources the stream, observes the core port)
interface prog_load_run_ctrl_if #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_WIDTH   = 32
);
  logic                    S_VALID;
  logic [DATA_WIDTH-1:0]   S_DATA;
  logic                    S_READY;
  logic                    W_EN;
  logic [ADDRESS_BITS-1:0] ADDRESS;
  logic [DATA_WIDTH-1:0]   W_INSTRUCTION;
  logic                    R_EN;
  logic                    CORE_RST;

  modport slave (
    input  S_VALID, S_DATA,
    output S_READY, W_EN, ADDRESS, W_INSTRUCTION, R_EN, CORE_RST
  );

  modport master (
    output S_VALID, S_DATA,
    input  S_READY, W_EN, ADDRESS, W_INSTRUCTION, R_EN, CORE_RST
  );
endinterface

// File: rtl/prog_load_run_ctrl.sv
// prog_load_run_ctrl
//   Sequences a single-cycle RISC-V core: streams a program into its
//   instruction memory, pulses the core reset, then gates execution through
//   R_EN as a bounded run, a free run until HALT_REQ, or a single step.
//   Ports:
//     CLK, RST        - clock (rising edge), async active-low reset
//     LOAD_START/LOAD_COUNT - start a load of LOAD_COUNT words at address 0
//     RUN_START/RUN_CYCLES  - start a run of RUN_CYCLES cycles (0 = free run)
//     STEP            - run exactly one core cycle
//     HALT_REQ        - stop a run or abort a load
//     BUSY            - controller not idle
//     LOAD_DONE, RUN_DONE, ERR - one-cycle status pulses
//     CYCLE_CNT       - saturating count of cycles with R_EN high
//     bus             - stream and core-facing signals (see interface)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for LOAD_START / RUN_START / STEP
//   LOAD  | accepting program words, writing them one cycle later
//   CRST  | final word written while the core is held in reset (1 cycle)
//   RUN   | R_EN high; down-counter or HALT_REQ ends the run
module prog_load_run_ctrl #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD_START,
  input  logic [ADDRESS_BITS:0] LOAD_COUNT,
  input  logic                  RUN_START,
  input  logic [CNT_WIDTH-1:0]  RUN_CYCLES,
  input  logic                  STEP,
  input  logic                  HALT_REQ,
  output logic                  BUSY,
  output logic                  LOAD_DONE,
  output logic                  RUN_DONE,
  output logic                  ERR,
  output logic [CNT_WIDTH-1:0]  CYCLE_CNT,
  prog_load_run_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CRST = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  localparam int                    DEPTH   = 2 ** ADDRESS_BITS;
  localparam logic [ADDRESS_BITS:0] DEPTH_C = DEPTH[ADDRESS_BITS:0];
  localparam logic [ADDRESS_BITS:0] REM_ONE = (ADDRESS_BITS + 1)'(1);
  localparam logic [CNT_WIDTH-1:0]  RUN_ONE = CNT_WIDTH'(1);

  logic [1:0]              state_q, state_d;
  logic [ADDRESS_BITS-1:0] ptr_q, ptr_d;
  logic [ADDRESS_BITS:0]   remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]    run_left_q, run_left_d;
  logic                    free_run_q, free_run_d;
  logic                    w_en_q, w_en_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    r_en_q, r_en_d;
  logic                    core_rst_q, core_rst_d;
  logic                    busy_q, busy_d;
  logic                    load_done_q, load_done_d;
  logic                    run_done_q, run_done_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic                    accept;
  logic                    count_ok;

  assign accept   = (state_q == LOAD) && bus.S_VALID;
  assign count_ok = (LOAD_COUNT != '0) && (LOAD_COUNT <= DEPTH_C);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    run_left_d  = run_left_q;
    free_run_d  = free_run_q;
    w_en_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    r_en_d      = 1'b0;
    load_done_d = 1'b0;
    run_done_d  = 1'b0;
    err_d       = 1'b0;
    cycle_cnt_d = cycle_cnt_q;

    // R_EN is only high in RUN, so this never collides with the load clear.
    if (r_en_q && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end

    // An accepted beat is written next cycle, even in an abort cycle.
    if (accept) begin
      w_en_d      = 1'b1;
      addr_d      = ptr_q;
      wdata_d     = bus.S_DATA;
      ptr_d       = ptr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (LOAD_START) begin
          if (count_ok) begin
            state_d     = LOAD;
            ptr_d       = '0;
            remaining_d = LOAD_COUNT;
            cycle_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (RUN_START) begin
          state_d    = RUN;
          r_en_d     = 1'b1;
          run_left_d = RUN_CYCLES;
          free_run_d = (RUN_CYCLES == '0);
        end else if (STEP) begin
          state_d    = RUN;
          r_en_d     = 1'b1;
          run_left_d = RUN_ONE;
          free_run_d = 1'b0;
        end
      end
      LOAD: begin
        if (HALT_REQ) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (accept && (remaining_q == REM_ONE)) begin
          state_d = CRST;
        end
      end
      CRST: begin
        state_d     = IDLE;
        load_done_d = 1'b1;
      end
      RUN: begin
        // Terminal count at 1: the current R_EN cycle is the last one.
        if (HALT_REQ || (!free_run_q && (run_left_q == RUN_ONE))) begin
          state_d    = IDLE;
          run_done_d = 1'b1;
        end else begin
          r_en_d = 1'b1;
          if (!free_run_q) begin
            run_left_d = run_left_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    core_rst_d = (state_d != CRST);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      run_left_q  <= '0;
      free_run_q  <= 1'b0;
      w_en_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      r_en_q      <= 1'b0;
      core_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      run_done_q  <= 1'b0;
      err_q       <= 1'b0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      run_left_q  <= run_left_d;
      free_run_q  <= free_run_d;
      w_en_q      <= w_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      r_en_q      <= r_en_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      run_done_q  <= run_done_d;
      err_q       <= err_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.S_READY       = (state_q == LOAD);
  assign bus.W_EN          = w_en_q;
  assign bus.ADDRESS       = addr_q;
  assign bus.W_INSTRUCTION = wdata_q;
  assign bus.R_EN          = r_en_q;
  assign bus.CORE_RST      = core_rst_q;
  assign BUSY              = busy_q;
  assign LOAD_DONE         = load_done_q;
  assign RUN_DONE          = run_done_q;
  assign ERR               = err_q;
  assign CYCLE_CNT         = cycle_cnt_q;

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
module tb_prog_load_run_ctrl;
  logic        CLK = 1'b0;
  logic        RST;
  logic        LOAD_START;
  logic [4:0]  LOAD_COUNT;
  logic        RUN_START;
  logic [15:0] RUN_CYCLES;
  logic        STEP;
  logic        HALT_REQ;
  logic        BUSY, LOAD_DONE, RUN_DONE, ERR;
  logic [15:0] CYCLE_CNT;

  prog_load_run_ctrl_if #(.ADDRESS_BITS(4), .DATA_WIDTH(32)) bus ();

  prog_load_run_ctrl #(.ADDRESS_BITS(4), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .LOAD_START (LOAD_START),
    .LOAD_COUNT (LOAD_COUNT),
    .RUN_START  (RUN_START),
    .RUN_CYCLES (RUN_CYCLES),
    .STEP       (STEP),
    .HALT_REQ   (HALT_REQ),
    .BUSY       (BUSY),
    .LOAD_DONE  (LOAD_DONE),
    .RUN_DONE   (RUN_DONE),
    .ERR        (ERR),
    .CYCLE_CNT  (CYCLE_CNT),
    .bus        (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: cumulative event counts and a write log, sampled mid-cycle.
  int          cyc = 0;
  int          n_ldone = 0, n_rdone = 0, n_err = 0, n_ren = 0;
  int          n_crst_low = 0, n_busy = 0, n_inv = 0;
  logic [3:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      if (bus.W_EN) begin
        wr_addr.push_back(bus.ADDRESS);
        wr_data.push_back(bus.W_INSTRUCTION);
        wr_cyc.push_back(cyc);
      end
      if (LOAD_DONE)     n_ldone++;
      if (RUN_DONE)      n_rdone++;
      if (ERR)           n_err++;
      if (bus.R_EN)      n_ren++;
      if (!bus.CORE_RST) n_crst_low++;
      if (BUSY)          n_busy++;
      if (bus.W_EN && bus.R_EN)     n_inv++;
      if (!bus.CORE_RST && bus.R_EN) n_inv++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (BUSY && k < 50) begin
      tick();
      k++;
    end
    chk("idle_timeout", (k >= 50), 1'b0);
  endtask

  // Issue LOAD_START, then drive S_VALID per pattern bit with data base+i.
  task automatic do_load(input logic [4:0] cnt, input logic [7:0] pat, input int npat,
                         input logic [31:0] base);
    LOAD_START = 1'b1;
    LOAD_COUNT = cnt;
    tick();
    LOAD_START = 1'b0;
    for (int i = 0; i < npat; i++) begin
      bus.S_VALID = pat[i];
      bus.S_DATA  = base + 32'(i);
      tick();
    end
    bus.S_VALID = 1'b0;
    repeat (3) tick();
  endtask

  int b_wr, b_ld, b_rd, b_err, b_ren, b_crst, b_busy;
  task automatic snap();
    b_wr = wr_addr.size(); b_ld = n_ldone; b_rd = n_rdone; b_err = n_err;
    b_ren = n_ren; b_crst = n_crst_low; b_busy = n_busy;
  endtask

  initial begin
    RST = 1'b0; LOAD_START = 1'b0; LOAD_COUNT = '0; RUN_START = 1'b0;
    RUN_CYCLES = '0; STEP = 1'b0; HALT_REQ = 1'b0;
    bus.S_VALID = 1'b0; bus.S_DATA = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_w_en", bus.W_EN, 0);
    chk("rst_r_en", bus.R_EN, 0);
    chk("rst_core_rst", bus.CORE_RST, 0);
    chk("rst_s_ready", bus.S_READY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cycle_cnt", CYCLE_CNT, 0);
    RST = 1'b1;
    tick();
    chk("rel_core_rst", bus.CORE_RST, 1);

    // 1: five words, S_VALID held high
    snap();
    do_load(5'd5, 8'b0001_1111, 6, 32'hA000_0000);
    chk("t1_nwr", wr_addr.size() - b_wr, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_addr%0d", i), wr_addr[b_wr+i], 4'(i));
      chk($sformatf("t1_data%0d", i), wr_data[b_wr+i], 32'hA000_0000 + 32'(i));
    end
    chk("t1_consec", wr_cyc[b_wr+4] - wr_cyc[b_wr], 4);
    chk("t1_crst_low", n_crst_low - b_crst, 1);
    chk("t1_load_done", n_ldone - b_ld, 1);
    chk("t1_err", n_err - b_err, 0);
    chk("t1_busy", BUSY, 0);
    chk("t1_core_rst", bus.CORE_RST, 1);

    // 2: three words, S_VALID pattern 1,0,0,1,0,1
    snap();
    do_load(5'd3, 8'b0010_1001, 6, 32'hB000_0000);
    chk("t2_nwr", wr_addr.size() - b_wr, 3);
    chk("t2_addr0", wr_addr[b_wr],   4'd0);
    chk("t2_addr1", wr_addr[b_wr+1], 4'd1);
    chk("t2_addr2", wr_addr[b_wr+2], 4'd2);
    chk("t2_data0", wr_data[b_wr],   32'hB000_0000);
    chk("t2_data1", wr_data[b_wr+1], 32'hB000_0003);
    chk("t2_data2", wr_data[b_wr+2], 32'hB000_0005);
    chk("t2_gap1", wr_cyc[b_wr+1] - wr_cyc[b_wr], 3);
    chk("t2_gap2", wr_cyc[b_wr+2] - wr_cyc[b_wr], 5);
    chk("t2_load_done", n_ldone - b_ld, 1);

    // 3: illegal counts 0 and 17
    snap();
    do_load(5'd0, 8'h00, 0, 32'h0);
    do_load(5'd17, 8'h01, 1, 32'hDEAD_0000);
    chk("t3_err", n_err - b_err, 2);
    chk("t3_busy", n_busy - b_busy, 0);
    chk("t3_nwr", wr_addr.size() - b_wr, 0);
    chk("t3_load_done", n_ldone - b_ld, 0);

    // 4: bounded run of 4, then two steps
    snap();
    chk("t4_cnt_start", CYCLE_CNT, 0);
    RUN_START = 1'b1; RUN_CYCLES = 16'd4;
    tick();
    RUN_START = 1'b0;
    chk("t4_r_en_on", bus.R_EN, 1);
    wait_idle();
    chk("t4_run_done_pulse", RUN_DONE, 1);
    chk("t4_r_en_off", bus.R_EN, 0);
    tick();
    chk("t4_ren", n_ren - b_ren, 4);
    chk("t4_cnt", CYCLE_CNT, 4);
    chk("t4_run_done", n_rdone - b_rd, 1);
    for (int s = 0; s < 2; s++) begin
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      wait_idle();
      tick();
    end
    chk("t4_step_ren", n_ren - b_ren, 6);
    chk("t4_step_cnt", CYCLE_CNT, 6);
    chk("t4_step_done", n_rdone - b_rd, 3);

    // 5: free run, LOAD_START ignored, HALT_REQ in the 7th R_EN cycle
    snap();
    RUN_START = 1'b1; RUN_CYCLES = 16'd0;
    tick();
    RUN_START = 1'b0;
    LOAD_START = 1'b1; LOAD_COUNT = 5'd2;
    repeat (6) tick();
    chk("t5_r_en_held", bus.R_EN, 1);
    chk("t5_s_ready", bus.S_READY, 0);
    LOAD_START = 1'b0;
    HALT_REQ = 1'b1;
    tick();
    HALT_REQ = 1'b0;
    chk("t5_r_en_off", bus.R_EN, 0);
    chk("t5_run_done", RUN_DONE, 1);
    chk("t5_busy", BUSY, 0);
    repeat (2) tick();
    chk("t5_ren", n_ren - b_ren, 7);
    chk("t5_cnt", CYCLE_CNT, 13);
    chk("t5_err", n_err - b_err, 0);
    chk("t5_nwr", wr_addr.size() - b_wr, 0);

    // 6: reset mid-load after 2 of 4 words
    LOAD_START = 1'b1; LOAD_COUNT = 5'd4;
    tick();
    LOAD_START = 1'b0;
    chk("t6_cnt_clr", CYCLE_CNT, 0);
    bus.S_VALID = 1'b1;
    bus.S_DATA  = 32'hC000_0001;
    tick();
    bus.S_DATA  = 32'hC000_0002;
    tick();
    chk("t6_w_en_pre", bus.W_EN, 1);
    chk("t6_addr_pre", bus.ADDRESS, 1);
    RST = 1'b0;
    #1;
    chk("t6_w_en", bus.W_EN, 0);
    chk("t6_addr", bus.ADDRESS, 0);
    chk("t6_wdata", bus.W_INSTRUCTION, 0);
    chk("t6_core_rst", bus.CORE_RST, 0);
    chk("t6_s_ready", bus.S_READY, 0);
    chk("t6_busy", BUSY, 0);
    bus.S_VALID = 1'b0;
    #1;
    RST = 1'b1;
    tick();
    chk("t6_rel_core_rst", bus.CORE_RST, 1);
    chk("t6_rel_s_ready", bus.S_READY, 0);
    chk("t6_rel_busy", BUSY, 0);

    chk("invariants", n_inv, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_load_run_ctrl.md
Name: prog_load_run_ctrl

Overview:
- Controller in front of the single-cycle RISC-V top.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through the core's W_EN/ADDRESS/W_INSTRUCTION port.
- Pulses the core reset, then sequences execution through R_EN: bounded run, free run until halt, or single step.
- Replaces hand-driven loading and enabling of the core.

Parameters:
- ADDRESS_BITS, 4, instruction-memory address width; DEPTH = 2**ADDRESS_BITS words.
- DATA_WIDTH, 32, instruction word width.
- CNT_WIDTH, 16, width of RUN_CYCLES and CYCLE_CNT.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- LOAD_START  input  1  start a program load at address 0.
- LOAD_COUNT  input  ADDRESS_BITS+1  words to load, sampled with LOAD_START.
- S_VALID  input  1  program word valid.
- S_DATA  input  DATA_WIDTH  program word.
- S_READY  output  1  controller accepts a word.
- RUN_START  input  1  start execution.
- RUN_CYCLES  input  CNT_WIDTH  cycles to run, sampled with RUN_START; 0 = run until HALT_REQ.
- STEP  input  1  execute exactly one core cycle.
- HALT_REQ  input  1  stop run or abort load.
- W_EN  output  1  instruction-memory write enable to core.
- ADDRESS  output  ADDRESS_BITS  write address to core.
- W_INSTRUCTION  output  DATA_WIDTH  write data to core.
- R_EN  output  1  core execute enable.
- CORE_RST  output  1  active-low reset to core.
- BUSY  output  1  high when state is not IDLE.
- LOAD_DONE  output  1  one-cycle pulse, load completed.
- RUN_DONE  output  1  one-cycle pulse, run/step finished.
- ERR  output  1  one-cycle pulse, rejected command or aborted load.
- CYCLE_CNT  output  CNT_WIDTH  number of cycles R_EN was high.

Behaviour:
- All outputs registered. The one exception is S_READY, which is decoded directly from the state register (S_READY = state==LOAD).
- Reset (RST=0, asynchronous, any time, including mid-load or mid-run):
  - State goes to IDLE.
  - W_EN, R_EN, S_READY, BUSY, LOAD_DONE, RUN_DONE and ERR go to 0.
  - ADDRESS, W_INSTRUCTION and CYCLE_CNT go to 0.
  - CORE_RST goes to 0, holding the core in reset. It rises to 1 on the first CLK edge after RST is released.
- States: IDLE, LOAD, CRST, RUN.
- IDLE command priority, same cycle: LOAD_START > RUN_START > STEP. Lower-priority commands are dropped.
- LOAD_START in IDLE:
  - If 1 <= LOAD_COUNT <= DEPTH: go to LOAD, clear the write pointer and CYCLE_CNT, set remaining = LOAD_COUNT.
  - Otherwise: ERR pulse, stay in IDLE.
- LOAD state:
  - S_READY=1. A beat is accepted when S_VALID && S_READY.
  - One cycle after acceptance: W_EN=1, ADDRESS=pointer, W_INSTRUCTION=S_DATA. Then the pointer increments.
  - No beat accepted: W_EN=0, and ADDRESS/W_INSTRUCTION hold their values.
  - S_VALID gaps are allowed with no limit.
  - After the last beat is accepted: go to CRST. The last write issues in that cycle.
- CRST (1 cycle): CORE_RST=0 and W_EN=1 for the final word. Then go to IDLE with a LOAD_DONE pulse and CORE_RST=1.
- HALT_REQ in LOAD:
  - Abort and go to IDLE with an ERR pulse. There is no LOAD_DONE and no core reset.
  - A beat accepted in the abort cycle is still written.
- RUN_START in IDLE:
  - Go to RUN. R_EN=1 from the next cycle.
  - RUN_CYCLES=N>0: R_EN stays high exactly N cycles. Then go to IDLE; RUN_DONE pulses in the first cycle with R_EN=0.
  - N=0: free run until HALT_REQ.
- HALT_REQ in RUN: R_EN=0 at the next edge, go to IDLE, RUN_DONE pulse. HALT_REQ is ignored in IDLE and CRST.
- STEP in IDLE: equivalent to RUN_START with N=1 (one R_EN cycle, then RUN_DONE).
- LOAD_START, RUN_START and STEP outside IDLE: ignored, no ERR.
- CYCLE_CNT:
  - Increments on every cycle with R_EN=1 and saturates at all-ones.
  - Cleared only by an accepted LOAD_START or by reset. It is not cleared by RUN_START.
- Invariants:
  - W_EN and R_EN are never high in the same cycle.
  - R_EN=0 whenever CORE_RST=0.
  - BUSY is high in LOAD, CRST and RUN.

Test Plan:
1. Load 5 words, S_VALID held high, LOAD_COUNT=5 -> W_EN high 5 consecutive cycles at ADDRESS 0..4 with matching data. CORE_RST low 1 cycle. LOAD_DONE pulses once.
2. Load LOAD_COUNT=3 with S_VALID toggling 1,0,0,1,0,1 -> exactly 3 writes at ADDRESS 0,1,2. No write in gap cycles.
3. LOAD_COUNT=0, then LOAD_COUNT=17 with ADDRESS_BITS=4 -> ERR pulse each time, BUSY stays 0, no W_EN.
4. RUN_START with RUN_CYCLES=4 after a load -> R_EN high exactly 4 cycles, CYCLE_CNT=4, RUN_DONE pulse. Then STEP twice -> CYCLE_CNT=6.
5. RUN_START with RUN_CYCLES=0, HALT_REQ after 7 cycles -> R_EN low at the next edge, RUN_DONE pulse. LOAD_START during the run is ignored.
6. RST=0 mid-load after 2 of 4 words -> all outputs zero immediately, CORE_RST=0. After release: IDLE, CORE_RST=1, S_READY=0.
